// File: rtl/ksa_replay_issue_if.sv
// rtl/ksa_replay_issue_if.sv - producer, adder-stage and sink handshake bundle for ksa_replay_issue
interface ksa_replay_issue_if #(
  parameter int DATA_W = 8
);
  // producer -> issue stage
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              src_cin;
  logic              src_vld;
  logic              src_rdy;
  // issue stage -> adder stage
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              add_vld;
  logic              add_rdy;
  // adder stage -> issue stage
  logic [DATA_W-1:0] res_sum;
  logic              res_cout;
  logic              res_vld;
  logic              res_rdy;
  logic              res_mismatch;
  // issue stage -> consumer
  logic [DATA_W-1:0] snk_sum;
  logic              snk_cout;
  logic              snk_err;
  logic              snk_vld;
  logic              snk_rdy;

  // environment view: drives producer, adder results and consumer ready
  modport master (
    output src_a, src_b, src_cin, src_vld,
    input  src_rdy,
    input  add_a, add_b, add_cin, add_vld,
    output add_rdy,
    output res_sum, res_cout, res_vld, res_mismatch,
    input  res_rdy,
    input  snk_sum, snk_cout, snk_err, snk_vld,
    output snk_rdy
  );

  // issue-stage view
  modport slave (
    input  src_a, src_b, src_cin, src_vld,
    output src_rdy,
    output add_a, add_b, add_cin, add_vld,
    input  add_rdy,
    input  res_sum, res_cout, res_vld, res_mismatch,
    output res_rdy,
    output snk_sum, snk_cout, snk_err, snk_vld,
    input  snk_rdy
  );
endinterface

// File: rtl/ksa_replay_issue.sv
// rtl/ksa_replay_issue.sv - issue/replay stage around a Razor-checked adder (optional stats: KSA_REPLAY_STATS_EN)
module ksa_replay_issue #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  ksa_replay_issue_if.slave   bus,
  output logic                busy
`ifdef KSA_REPLAY_STATS_EN
  ,
  output logic [15:0]         replay_cnt,
  output logic [15:0]         force_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic              mem_cin [DEPTH];
  logic [PW-1:0]     head, head_nxt;
  logic [PW-1:0]     iss, iss_nxt;
  logic [PW-1:0]     tail, tail_nxt;
  logic [PW-1:0]     inflight, inflight_nxt;
  logic [PW-1:0]     discard, discard_nxt;
  logic [RW-1:0]     retry, retry_nxt;
  logic [PW-1:0]     occupancy;
  logic              full;
  logic              res_live;
  logic              at_limit;
  logic              replay;
  logic              retire;
  logic              src_fire;
  logic              add_fire;
  logic              res_fire;

  assign occupancy = tail - head;
  assign full      = (occupancy == PW'(DEPTH));
  // A result only belongs to us if something is in flight; stale results after reset are ignored.
  assign res_live  = bus.res_vld && (inflight != '0);
  assign at_limit  = (retry == RW'(MAX_RETRY));
  assign busy      = (tail != head) || (state != RUN);

  // Handshake outputs: issue side, and pass-through / drop decision on the result side
  always_comb begin
    bus.src_rdy  = !full && (state == RUN);
    bus.add_vld  = (state == RUN) && (iss != tail);
    bus.add_a    = mem_a[iss[AW-1:0]];
    bus.add_b    = mem_b[iss[AW-1:0]];
    bus.add_cin  = mem_cin[iss[AW-1:0]];
    bus.snk_sum  = bus.res_sum;
    bus.snk_cout = bus.res_cout;
    bus.snk_vld  = 1'b0;
    bus.snk_err  = 1'b0;
    bus.res_rdy  = 1'b0;
    replay       = 1'b0;
    if (state == RUN) begin
      if (res_live && bus.res_mismatch && !at_limit) begin
        bus.res_rdy = 1'b1;
        replay      = 1'b1;
      end else begin
        bus.snk_vld = res_live;
        bus.snk_err = res_live && bus.res_mismatch;
        bus.res_rdy = bus.snk_rdy && (inflight != '0);
      end
    end else begin
      bus.res_rdy = (inflight != '0);
    end
  end

  assign src_fire = bus.src_vld && bus.src_rdy;
  assign add_fire = bus.add_vld && bus.add_rdy;
  assign res_fire = res_live && bus.res_rdy;
  assign retire   = (state == RUN) && res_fire && !replay;

  // Pointer, accounting and replay next-state
  always_comb begin
    state_nxt    = state;
    head_nxt     = head;
    iss_nxt      = iss + PW'(add_fire);
    tail_nxt     = tail + PW'(src_fire);
    inflight_nxt = inflight + PW'(add_fire) - PW'(res_fire);
    discard_nxt  = discard;
    retry_nxt    = retry;
    if (retire) begin
      head_nxt  = head + PW'(1);
      retry_nxt = '0;
    end
    if (replay) begin
      // An op issued in this same cycle is already counted in inflight_nxt and must be drained too.
      retry_nxt   = retry + RW'(1);
      iss_nxt     = head;
      discard_nxt = inflight_nxt;
      state_nxt   = (inflight_nxt == '0) ? RUN : DRAIN;
    end
    if (state == DRAIN) begin
      if (res_fire) begin
        discard_nxt = discard - PW'(1);
        if (discard <= PW'(1)) state_nxt = RUN;
      end else if (discard == '0) begin
        state_nxt = RUN;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      head     <= '0;
      iss      <= '0;
      tail     <= '0;
      inflight <= '0;
      discard  <= '0;
      retry    <= '0;
    end else begin
      state    <= state_nxt;
      head     <= head_nxt;
      iss      <= iss_nxt;
      tail     <= tail_nxt;
      inflight <= inflight_nxt;
      discard  <= discard_nxt;
      retry    <= retry_nxt;
    end
  end

  // Retain buffer write at tail; contents need no reset
  always_ff @(posedge clk) begin
    if (src_fire) begin
      mem_a[tail[AW-1:0]]   <= bus.src_a;
      mem_b[tail[AW-1:0]]   <= bus.src_b;
      mem_cin[tail[AW-1:0]] <= bus.src_cin;
    end
  end

`ifdef KSA_REPLAY_STATS_EN
  // Saturating replay and forced-retire event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_cnt <= '0;
      force_cnt  <= '0;
    end else begin
      if (replay && (replay_cnt != 16'hFFFF)) replay_cnt <= replay_cnt + 16'd1;
      if (retire && bus.snk_err && (force_cnt != 16'hFFFF)) force_cnt <= force_cnt + 16'd1;
    end
  end
`endif
endmodule
